// File: rtl/regfile_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl_pkg
//   Shared definitions for the register-file access controller: FSM state
//   encoding and the fixed register indices the controller treats specially.
// -----------------------------------------------------------------------------
package regfile_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,   // hardware clearing sweep of x1..x31
        ST_RUN  = 2'd1,   // core owns the register file, debug may be accepted
        ST_DBG  = 2'd2,   // single stall cycle servicing the debug access
        ST_RSP  = 2'd3    // debug response held until consumed
    } state_e;

    localparam logic [4:0] REG_X0   = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd2;
    localparam logic [4:0] LAST_REG = 5'd31;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl_if
//   Bundles every non-clock/reset signal of the register-file access controller:
//     core_*      core writeback and rs1 address, plus core_stall back to core
//     init_done   initialisation sweep finished
//     dbg_req_*   debug request channel (valid/ready, we, addr, wdata)
//     dbg_rsp_*   debug response channel (valid/ready, rdata)
//     rf_*        register-file write port and rs1 read port
//   modport slave  : the controller
//   modport master : the surrounding core / debug agent / register file
// -----------------------------------------------------------------------------
interface regfile_access_ctrl_if #(
    parameter int XLEN = 32
);
    logic            core_regwrite;
    logic [4:0]      core_rd;
    logic [XLEN-1:0] core_wd;
    logic [4:0]      core_rs1;
    logic            core_stall;
    logic            init_done;

    logic            dbg_req_valid;
    logic            dbg_req_ready;
    logic            dbg_req_we;
    logic [4:0]      dbg_req_addr;
    logic [XLEN-1:0] dbg_req_wdata;
    logic            dbg_rsp_valid;
    logic            dbg_rsp_ready;
    logic [XLEN-1:0] dbg_rsp_rdata;

    logic            rf_regwrite;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic [4:0]      rf_rs1;
    logic [XLEN-1:0] rf_rs1_data;

    modport master (
        output core_regwrite, core_rd, core_wd, core_rs1,
        output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
        output dbg_rsp_ready, rf_rs1_data,
        input  core_stall, init_done, dbg_req_ready, dbg_rsp_valid,
        input  dbg_rsp_rdata, rf_regwrite, rf_rd, rf_wd, rf_rs1
    );

    modport slave (
        input  core_regwrite, core_rd, core_wd, core_rs1,
        input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
        input  dbg_rsp_ready, rf_rs1_data,
        output core_stall, init_done, dbg_req_ready, dbg_rsp_valid,
        output dbg_rsp_rdata, rf_regwrite, rf_rd, rf_wd, rf_rs1
    );

endinterface

// File: rtl/regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl
//   Owns the register file's write port and rs1 read port. After reset it
//   sweeps x1..x31 to zero (x2 gets SP_INIT), then shares the register file
//   between core writeback and a debug request/response port. Each debug
//   access costs exactly one core stall cycle.
//
//   Ports:
//     clk    clock
//     reset  synchronous active-low reset (0 = reset)
//     bus    regfile_access_ctrl_if.slave: core, debug and register-file signals
// -----------------------------------------------------------------------------
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] SP_INIT    = 32'h100,
    parameter int              INIT_SWEEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_access_ctrl_if.slave bus
);

    localparam state_e RESET_STATE = (INIT_SWEEP != 0) ? ST_INIT : ST_RUN;

    state_e          state_q,     state_d;
    logic [4:0]      cnt_q,       cnt_d;
    logic            init_done_q, init_done_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            dbg_we_q,    dbg_we_d;
    logic [4:0]      dbg_addr_q,  dbg_addr_d;
    logic [XLEN-1:0] dbg_wdata_q, dbg_wdata_d;

    // Next-state and register-file port mux
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        dbg_we_d    = dbg_we_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_wdata_d = dbg_wdata_q;

        // Core path is the default owner of both ports.
        bus.rf_regwrite   = bus.core_regwrite;
        bus.rf_rd         = bus.core_rd;
        bus.rf_wd         = bus.core_wd;
        bus.rf_rs1        = bus.core_rs1;
        bus.core_stall    = (state_q == ST_INIT) || (state_q == ST_DBG);
        bus.dbg_req_ready = (state_q == ST_RUN);

        case (state_q)
            ST_INIT: begin
                bus.rf_regwrite = 1'b1;
                bus.rf_rd       = cnt_q;
                bus.rf_wd       = (cnt_q == REG_SP) ? SP_INIT : '0;
                if (cnt_q == LAST_REG) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            ST_RUN: begin
                // Covers the no-sweep configuration, where RUN follows reset directly.
                init_done_d = 1'b1;
                if (bus.dbg_req_valid) begin
                    dbg_we_d    = bus.dbg_req_we;
                    dbg_addr_d  = bus.dbg_req_addr;
                    dbg_wdata_d = bus.dbg_req_wdata;
                    state_d     = ST_DBG;
                end
            end

            ST_DBG: begin
                // Debug side owns both ports; the stalled core re-presents its
                // blocked write next cycle. A core write committed in the accept
                // cycle is already visible here, so reads observe it.
                bus.rf_regwrite = dbg_we_q && (dbg_addr_q != REG_X0);
                bus.rf_rd       = dbg_addr_q;
                bus.rf_wd       = dbg_wdata_q;
                bus.rf_rs1      = dbg_addr_q;
                rsp_rdata_d     = (dbg_we_q || (dbg_addr_q == REG_X0)) ? '0 : bus.rf_rs1_data;
                rsp_valid_d     = 1'b1;
                state_d         = ST_RSP;
            end

            ST_RSP: begin
                if (bus.dbg_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_RUN;
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign bus.init_done     = init_done_q;
    assign bus.dbg_rsp_valid = rsp_valid_q;
    assign bus.dbg_rsp_rdata = rsp_rdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            cnt_q       <= 5'd1;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            dbg_we_q    <= 1'b0;
            dbg_addr_q  <= REG_X0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            dbg_we_q    <= dbg_we_d;
            dbg_addr_q  <= dbg_addr_d;
        end
        dbg_wdata_q <= dbg_wdata_d;
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_ctrl
//   Self-checking bench for regfile_access_ctrl with a behavioural 32x32
//   register file (write on posedge, combinational rs1 read, x0 reads zero).
// -----------------------------------------------------------------------------
module tb_regfile_access_ctrl;

    logic clk;
    logic reset;

    regfile_access_ctrl_if #(.XLEN(32)) bus ();

    regfile_access_ctrl #(
        .XLEN      (32),
        .SP_INIT   (32'h100),
        .INIT_SWEEP(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end
    always @(posedge clk) begin
        if (bus.rf_regwrite && (bus.rf_rd != 5'd0)) mem[bus.rf_rd] <= bus.rf_wd;
    end
    assign bus.rf_rs1_data = (bus.rf_rs1 == 5'd0) ? 32'd0 : mem[bus.rf_rs1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        core_we;
        logic [4:0]  core_rd;
        logic [31:0] core_wd;
        logic [31:0] exp_rdata;
        logic        exp_rfwe;
    } vec_t;

    vec_t vecs [9];

    // Runs one debug transaction starting at a RUN-state negedge, with
    // dbg_rsp_ready already high. Ends at a RUN-state negedge.
    task automatic do_dbg(input vec_t v);
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_we    = v.we;
        bus.dbg_req_addr  = v.addr;
        bus.dbg_req_wdata = v.wdata;
        bus.core_regwrite = v.core_we;
        bus.core_rd       = v.core_rd;
        bus.core_wd       = v.core_wd;
        #1;
        check({v.name, "_acc_ready"}, 32'(bus.dbg_req_ready), 32'd1);
        check({v.name, "_acc_stall"}, 32'(bus.core_stall), 32'd0);
        check({v.name, "_acc_rfwe"},  32'(bus.rf_regwrite), 32'(v.core_we));
        step();
        bus.dbg_req_valid = 1'b0;
        settle();
        check({v.name, "_dbg_stall"}, 32'(bus.core_stall), 32'd1);
        check({v.name, "_dbg_rfwe"},  32'(bus.rf_regwrite), 32'(v.exp_rfwe));
        check({v.name, "_dbg_rspv"},  32'(bus.dbg_rsp_valid), 32'd0);
        if (v.we) begin
            check({v.name, "_dbg_rd"}, 32'(bus.rf_rd), 32'(v.addr));
            check({v.name, "_dbg_wd"}, bus.rf_wd, v.wdata);
        end
        step();
        settle();
        check({v.name, "_rsp_valid"}, 32'(bus.dbg_rsp_valid), 32'd1);
        check({v.name, "_rsp_rdata"}, bus.dbg_rsp_rdata, v.exp_rdata);
        check({v.name, "_rsp_stall"}, 32'(bus.core_stall), 32'd0);
        check({v.name, "_rsp_ready"}, 32'(bus.dbg_req_ready), 32'd0);
        check({v.name, "_rsp_corewe"}, 32'(bus.rf_regwrite), 32'(v.core_we));
        step();
        bus.core_regwrite = 1'b0;
        settle();
        check({v.name, "_done_rspv"}, 32'(bus.dbg_rsp_valid), 32'd0);
        check({v.name, "_done_ready"}, 32'(bus.dbg_req_ready), 32'd1);
    endtask

    // Counts cycles until init_done, starting at an INIT-state negedge with
    // reset high and the sweep at x1.
    task automatic wait_sweep(input string name);
        int cyc;
        cyc = 0;
        check({name, "_first_rd"}, 32'(bus.rf_rd), 32'd1);
        while (!bus.init_done && cyc < 100) begin
            step();
            settle();
            cyc++;
            if (cyc == 1) check({name, "_second_rd"}, 32'(bus.rf_rd), 32'd2);
        end
        check({name, "_len"}, 32'(cyc), 32'd31);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0] = '{"wr_x5",    1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    32'h0,        1'b1};
        vecs[1] = '{"rd_x5",    1'b0, 5'd5,  32'h0,        1'b0, 5'd0, 32'h0,    32'hDEADBEEF, 1'b0};
        vecs[2] = '{"rd_x7_fw", 1'b0, 5'd7,  32'h0,        1'b1, 5'd7, 32'h1234, 32'h1234,     1'b0};
        vecs[3] = '{"wr_x0",    1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,    32'h0,        1'b0};
        vecs[4] = '{"rd_x0",    1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    32'h0,        1'b0};
        vecs[5] = '{"rd_x2",    1'b0, 5'd2,  32'h0,        1'b0, 5'd0, 32'h0,    32'h100,      1'b0};
        vecs[6] = '{"wr_x31",   1'b1, 5'd31, 32'h0BADF00D, 1'b1, 5'd3, 32'h55,   32'h0,        1'b1};
        vecs[7] = '{"rd_x31",   1'b0, 5'd31, 32'h0,        1'b0, 5'd0, 32'h0,    32'h0BADF00D, 1'b0};
        vecs[8] = '{"rd_x3",    1'b0, 5'd3,  32'h0,        1'b0, 5'd0, 32'h0,    32'h55,       1'b0};

        reset             = 1'b0;
        bus.core_regwrite = 1'b0;
        bus.core_rd       = 5'd0;
        bus.core_wd       = 32'd0;
        bus.core_rs1      = 5'd0;
        bus.dbg_req_valid = 1'b0;
        bus.dbg_req_we    = 1'b0;
        bus.dbg_req_addr  = 5'd0;
        bus.dbg_req_wdata = 32'd0;
        bus.dbg_rsp_ready = 1'b1;

        // Reset state
        step();
        step();
        settle();
        check("rst_init_done", 32'(bus.init_done), 32'd0);
        check("rst_rsp_valid", 32'(bus.dbg_rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.dbg_rsp_rdata, 32'd0);
        check("rst_stall",     32'(bus.core_stall), 32'd1);
        reset = 1'b1;

        // Initialisation sweep: 31 write cycles, x1..x31
        for (int i = 1; i <= 31; i++) begin
            check($sformatf("sweep%0d_we", i),    32'(bus.rf_regwrite), 32'd1);
            check($sformatf("sweep%0d_rd", i),    32'(bus.rf_rd), 32'(i));
            check($sformatf("sweep%0d_wd", i),    bus.rf_wd, (i == 2) ? 32'h100 : 32'h0);
            check($sformatf("sweep%0d_stall", i), 32'(bus.core_stall), 32'd1);
            check($sformatf("sweep%0d_done", i),  32'(bus.init_done), 32'd0);
            check($sformatf("sweep%0d_ready", i), 32'(bus.dbg_req_ready), 32'd0);
            step();
            settle();
        end
        check("run_init_done", 32'(bus.init_done), 32'd1);
        check("run_stall",     32'(bus.core_stall), 32'd0);
        check("run_ready",     32'(bus.dbg_req_ready), 32'd1);
        check("run_rfwe",      32'(bus.rf_regwrite), 32'd0);
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            if (mem[i] !== ((i == 2) ? 32'h100 : 32'h0)) bad++;
        end
        check("sweep_contents_bad", 32'(bad), 32'd0);

        // Table-driven debug transactions
        for (int k = 0; k < 9; k++) do_dbg(vecs[k]);
        check("x0_untouched_by_dbg", mem[0], 32'hA5A5_0000);

        // Response back-pressure: hold ready low for 5 RSP cycles
        bus.dbg_rsp_ready = 1'b0;
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_we    = 1'b0;
        bus.dbg_req_addr  = 5'd5;
        step();
        bus.dbg_req_addr  = 5'd9;
        step();
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("hold%0d_valid", k), 32'(bus.dbg_rsp_valid), 32'd1);
            check($sformatf("hold%0d_rdata", k), bus.dbg_rsp_rdata, 32'hDEADBEEF);
            check($sformatf("hold%0d_ready", k), 32'(bus.dbg_req_ready), 32'd0);
            check($sformatf("hold%0d_stall", k), 32'(bus.core_stall), 32'd0);
            step();
        end
        bus.dbg_req_valid = 1'b0;
        bus.dbg_rsp_ready = 1'b1;
        step();
        settle();
        check("hold_release_valid", 32'(bus.dbg_rsp_valid), 32'd0);
        check("hold_release_ready", 32'(bus.dbg_req_ready), 32'd1);

        // Reset taken during DBG
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_we    = 1'b0;
        bus.dbg_req_addr  = 5'd5;
        step();
        bus.dbg_req_valid = 1'b0;
        reset = 1'b0;
        settle();
        check("rdbg_in_dbg_stall", 32'(bus.core_stall), 32'd1);
        step();
        settle();
        check("rdbg_rsp_valid", 32'(bus.dbg_rsp_valid), 32'd0);
        check("rdbg_init_done", 32'(bus.init_done), 32'd0);
        check("rdbg_stall",     32'(bus.core_stall), 32'd1);
        reset = 1'b1;
        wait_sweep("rdbg_sweep");

        // Reset taken during RSP
        bus.dbg_rsp_ready = 1'b0;
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_we    = 1'b0;
        bus.dbg_req_addr  = 5'd2;
        step();
        bus.dbg_req_valid = 1'b0;
        step();
        settle();
        check("rrsp_pre_valid", 32'(bus.dbg_rsp_valid), 32'd1);
        check("rrsp_pre_rdata", bus.dbg_rsp_rdata, 32'h100);
        reset = 1'b0;
        step();
        settle();
        check("rrsp_rsp_valid", 32'(bus.dbg_rsp_valid), 32'd0);
        check("rrsp_rsp_rdata", bus.dbg_rsp_rdata, 32'd0);
        reset = 1'b1;
        bus.dbg_rsp_ready = 1'b1;
        wait_sweep("rrsp_sweep");

        // The restarted sweep cleared registers written by debug earlier
        do_dbg('{"rd_x5_clr", 1'b0, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
